melody_sequencer: RTL and testbench

Plays a programmable melody of up to DEPTH note entries and drives the note/tone inputs of the 7-segment note display decoder. Each entry holds a 3-bit note code, a tone bit and a duration in beat ticks. A write port loads entries, and start/stop/loop controls sequence playback. The block sits between the user control logic and the display decoder; its outputs feed the decoder's note and tone inputs directly.

---
 rtl/melody_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 32 +++
 rtl/melody_sequencer.sv | 171 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_pkg.sv
// Shared types for the melody sequencer: sequence entry layout and FSM states.
package melody_pkg;

  localparam int DUR_W_DEF = 4;

  typedef struct packed {
    logic [2:0]           notas;
    logic                 tom;
    logic [DUR_W_DEF-1:0] dur;
  } note_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOTE = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Beat-tick prescaler: one-cycle tick every TICK_DIV enabled cycles, synchronous clear.
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = en & w_last;

  // Free-running beat counter, held at zero while cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer top: entry memory, playback FSM and registered display outputs.
// Build with MELODY_GAP_EN defined to insert a one-tick blank between notes.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int DUR_W    = DUR_W_DEF,
  parameter int TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [2:0]               wr_notas,
  input  logic                     wr_tom,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic [$clog2(DEPTH):0]   seq_len,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  output logic [2:0]               notas_o,
  output logic                     tom_o,
  output logic                     disp_en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [2:0]       r_mem_notas [DEPTH];
  logic             r_mem_tom   [DEPTH];
  logic [DUR_W-1:0] r_mem_dur   [DEPTH];

  state_t           r_state;
  logic [LW-1:0]    r_len;
  logic [AW-1:0]    r_idx;
  logic [DUR_W-1:0] r_dur_cnt;

  logic             w_tick;
  logic             w_has_next;
  logic [AW-1:0]    w_next_idx;
  logic [DUR_W-1:0] w_dur0;
  logic [DUR_W-1:0] w_dur_next;

  assign w_has_next = ({1'b0, r_idx} + LW'(1)) < r_len;
  assign w_next_idx = w_has_next ? r_idx + AW'(1) : '0;
  // A stored duration of zero still plays for one tick
  assign w_dur0     = (r_mem_dur[0] == '0) ? DUR_W'(1) : r_mem_dur[0];
  assign w_dur_next = (r_mem_dur[w_next_idx] == '0) ? DUR_W'(1) : r_mem_dur[w_next_idx];

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (r_state == IDLE),
    .en    (r_state != IDLE),
    .tick  (w_tick)
  );

  // Sequence memory write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_notas[i] <= '0;
        r_mem_tom[i]   <= 1'b0;
        r_mem_dur[i]   <= '0;
      end
    end else if (wr_en) begin
      r_mem_notas[wr_addr] <= wr_notas;
      r_mem_tom[wr_addr]   <= wr_tom;
      r_mem_dur[wr_addr]   <= wr_dur;
    end
  end

  // Playback FSM; note and tone are latched on entry so rewrites of the playing slot are invisible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_len     <= '0;
      r_idx     <= '0;
      r_dur_cnt <= '0;
      notas_o   <= 3'd0;
      tom_o     <= 1'b0;
      disp_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        r_state  <= IDLE;
        notas_o  <= 3'd0;
        tom_o    <= 1'b0;
        disp_en  <= 1'b0;
        busy     <= 1'b0;
        step_idx <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && (seq_len != '0)) begin
              r_len     <= (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
              r_idx     <= '0;
              step_idx  <= '0;
              notas_o   <= r_mem_notas[0];
              tom_o     <= r_mem_tom[0];
              r_dur_cnt <= w_dur0;
              disp_en   <= 1'b1;
              busy      <= 1'b1;
              r_state   <= NOTE;
            end
          end
          NOTE: begin
            if (w_tick) begin
              if (r_dur_cnt != DUR_W'(1)) begin
                r_dur_cnt <= r_dur_cnt - DUR_W'(1);
              end else if (w_has_next || loop_en) begin
`ifdef MELODY_GAP_EN
                r_state <= GAP;
                notas_o <= 3'd0;
                tom_o   <= 1'b0;
                disp_en <= 1'b0;
`else
                r_idx     <= w_next_idx;
                step_idx  <= w_next_idx;
                notas_o   <= r_mem_notas[w_next_idx];
                tom_o     <= r_mem_tom[w_next_idx];
                r_dur_cnt <= w_dur_next;
`endif
              end else begin
                done     <= 1'b1;
                r_state  <= IDLE;
                notas_o  <= 3'd0;
                tom_o    <= 1'b0;
                disp_en  <= 1'b0;
                busy     <= 1'b0;
                step_idx <= '0;
              end
            end
          end
`ifdef MELODY_GAP_EN
          // GAP is only entered when a next entry exists, so w_next_idx already encodes the wrap
          GAP: begin
            if (w_tick) begin
              r_idx     <= w_next_idx;
              step_idx  <= w_next_idx;
              notas_o   <= r_mem_notas[w_next_idx];
              tom_o     <= r_mem_tom[w_next_idx];
              r_dur_cnt <= w_dur_next;
              disp_en   <= 1'b1;
              r_state   <= NOTE;
            end
          end
`endif
          default: begin
            r_state  <= IDLE;
            notas_o  <= 3'd0;
            tom_o    <= 1'b0;
            disp_en  <= 1'b0;
            busy     <= 1'b0;
            step_idx <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer (TICK_DIV=4): stimulus queues expected display
// segments, a monitor collapses DUT outputs into segments/done events and compares.
module tb_melody_sequencer;
  import melody_pkg::*;

  localparam int DEPTH    = 16;
  localparam int DUR_W    = 4;
  localparam int TICK_DIV = 4;
  localparam int AW       = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [2:0]    wr_notas = '0;
  logic          wr_tom = 1'b0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic [AW:0]   seq_len = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop_en = 1'b0;
  logic [2:0]    notas_o;
  logic          tom_o;
  logic          disp_en;
  logic          busy;
  logic          done;
  logic [AW-1:0] step_idx;

  always #5 clk = ~clk;

  melody_sequencer #(
    .DEPTH(DEPTH), .DUR_W(DUR_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_notas(wr_notas),
    .wr_tom(wr_tom), .wr_dur(wr_dur), .seq_len(seq_len), .start(start), .stop(stop),
    .loop_en(loop_en), .notas_o(notas_o), .tom_o(tom_o), .disp_en(disp_en), .busy(busy),
    .done(done), .step_idx(step_idx)
  );

  typedef struct packed {
    logic        is_done;
    logic        disp;
    logic [2:0]  notas;
    logic        tom;
    logic [3:0]  idx;
    logic [15:0] len;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic emit(input rec_t act);
    rec_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL seg_unexpected: got done=%0d disp=%0d notas=%0d tom=%0d idx=%0d len=%0d, expected nothing",
               act.is_done, act.disp, act.notas, act.tom, act.idx, act.len);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL seg: got done=%0d disp=%0d notas=%0d tom=%0d idx=%0d len=%0d expected done=%0d disp=%0d notas=%0d tom=%0d idx=%0d len=%0d",
                 act.is_done, act.disp, act.notas, act.tom, act.idx, act.len,
                 e.is_done, e.disp, e.notas, e.tom, e.idx, e.len);
      end
    end
  endtask

  function automatic void push_note(input int n, input int t, input int i, input int cycles);
    exp_q.push_back(rec_t'{1'b0, 1'b1, 3'(n), 1'(t), 4'(i), 16'(cycles)});
  endfunction

  function automatic void push_gap();
`ifdef MELODY_GAP_EN
    exp_q.push_back(rec_t'{1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 16'd4});
`endif
  endfunction

  function automatic void push_done();
    exp_q.push_back(rec_t'{1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 16'd0});
  endfunction

  // Monitor: a segment is a run of busy cycles with constant display outputs
  rec_t mon_cur;
  rec_t mon_now;
  int   mon_len = 0;
  bit   mon_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_valid = 1'b0;
    end else begin
      mon_now = rec_t'{1'b0, disp_en, notas_o, tom_o, (disp_en ? step_idx : 4'd0), 16'd0};
      if (mon_valid && busy && (mon_now == mon_cur)) begin
        mon_len++;
      end else begin
        if (mon_valid) begin
          mon_cur.len = 16'(mon_len);
          emit(mon_cur);
        end
        mon_valid = busy;
        mon_cur   = mon_now;
        mon_len   = 1;
      end
      if (done) emit(rec_t'{1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 16'd0});
    end
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_entry(input int addr, input note_entry_t e);
    wr_addr = AW'(addr); wr_notas = e.notas; wr_tom = e.tom; wr_dur = e.dur; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic start_play(input int len);
    seq_len = 5'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2 rst_n = 1'b0;
    run_cycles(2);
    check("rst_notas", notas_o, 0);
    check("rst_tom", tom_o, 0);
    check("rst_disp", disp_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    run_cycles(2);

    // Cleared memory, dur=0 entry plays one tick
    push_note(0, 0, 0, 4); push_done();
    start_play(1);
    wait_idle("zero_mem_idle", 100);
    run_cycles(2);

    // Basic program
    write_entry(0, '{3'd1, 1'b0, 4'd2});
    write_entry(1, '{3'd5, 1'b1, 4'd1});
    write_entry(2, '{3'd3, 1'b0, 4'd3});
    push_note(1, 0, 0, 8); push_gap(); push_note(5, 1, 1, 4); push_gap();
    push_note(3, 0, 2, 12); push_done();
    start_play(3);
    wait_idle("basic_idle", 200);
    check("basic_disp_after", disp_en, 0);
    run_cycles(2);

    // Loop once, then clear loop_en during the second pass of entry 2
    loop_en = 1'b1;
    push_note(1, 0, 0, 8); push_gap(); push_note(5, 1, 1, 4); push_gap(); push_note(3, 0, 2, 12); push_gap();
    push_note(1, 0, 0, 8); push_gap(); push_note(5, 1, 1, 4); push_gap(); push_note(3, 0, 2, 12); push_done();
    start_play(3);
`ifdef MELODY_GAP_EN
    run_cycles(60);
`else
    run_cycles(40);
`endif
    loop_en = 1'b0;
    wait_idle("loop_idle", 200);
    run_cycles(2);

    // Stop three cycles into entry 1, then start with stop held
    push_note(1, 0, 0, 8); push_gap(); push_note(5, 1, 1, 3);
    start_play(3);
`ifdef MELODY_GAP_EN
    run_cycles(14);
`else
    run_cycles(10);
`endif
    stop = 1'b1;
    run_cycles(1);
    check("stop_busy", busy, 0);
    check("stop_disp", disp_en, 0);
    seq_len = 5'd3; start = 1'b1;
    run_cycles(3);
    check("stop_start_busy", busy, 0);
    start = 1'b0; stop = 1'b0;
    run_cycles(2);

    // seq_len=0 is ignored
    start_play(0);
    run_cycles(3);
    check("len0_busy", busy, 0);

    // seq_len above DEPTH clamps; rewrite playing entry 0 and upcoming entry 5
    for (int i = 3; i < 16; i++) write_entry(i, '{3'(i % 8), 1'(i % 2), 4'd1});
    push_note(1, 0, 0, 8); push_gap(); push_note(5, 1, 1, 4); push_gap(); push_note(3, 0, 2, 12);
    for (int i = 3; i < 16; i++) begin
      push_gap();
      if (i == 5) push_note(6, 1, 5, 8);
      else        push_note(i % 8, i % 2, i, 4);
    end
    push_done();
    start_play(20);
    write_entry(0, '{3'd7, 1'b1, 4'd5});
    write_entry(5, '{3'd6, 1'b1, 4'd2});
    wait_idle("len20_idle", 400);
    run_cycles(2);

    // Asynchronous reset mid-playback clears outputs and memory
    start_play(3);
    run_cycles(3);
    rst_n = 1'b0;
    #1;
    check("midrst_notas", notas_o, 0);
    check("midrst_tom", tom_o, 0);
    check("midrst_disp", disp_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    run_cycles(2);
    rst_n = 1'b1;
    run_cycles(1);
    push_note(0, 0, 0, 4); push_gap(); push_note(0, 0, 1, 4); push_done();
    start_play(2);
    wait_idle("postrst_idle", 100);
    run_cycles(3);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
